ldtu_sample_packer: RTL and testbench

//  Downstream of the input-FIFO/gain-select stage. Takes one 13-bit sample plus baseline flag every CLK cycle.

---
 rtl/ldtu_sample_packer_if.sv | 38 +++
 rtl/ldtu_sample_packer.sv | 179 +++++++++++++++++
 tb/tb_ldtu_sample_packer.sv | 238 +++++++++++++++++++++++
 3 files changed

// File: rtl/ldtu_sample_packer_if.sv
// ---------------------------------------------------------------------------
// ldtu_sample_packer_if
// Purpose : groups the sample input bus and the packed-word valid/ready bus
//           of ldtu_sample_packer.
// Signals : DATA_to_enc[12:0]  sample; [12] = gain flag, [11:0] = data
//           baseline_flag      1 = baseline sample (only [5:0] significant)
//           word_data[31:0]    head-of-FIFO packed word
//           word_valid         FIFO not empty
//           word_ready         consumer accepts word_data this cycle
// Modports: slave  - the packer (consumes samples, produces words)
//           master - the surrounding logic (feeds samples, consumes words)
// Handshake: a word transfers on a CLK edge where word_valid & word_ready are
//           both 1. While word_valid=1 and word_ready=0, word_data holds.
//           word_data is meaningless while word_valid=0.
// ---------------------------------------------------------------------------
interface ldtu_sample_packer_if;
    logic [12:0] DATA_to_enc;
    logic        baseline_flag;
    logic [31:0] word_data;
    logic        word_valid;
    logic        word_ready;

    modport slave (
        input  DATA_to_enc,
        input  baseline_flag,
        input  word_ready,
        output word_data,
        output word_valid
    );

    modport master (
        output DATA_to_enc,
        output baseline_flag,
        output word_ready,
        input  word_data,
        input  word_valid
    );
endinterface

// File: rtl/ldtu_sample_packer.sv
// ---------------------------------------------------------------------------
// ldtu_sample_packer
// Purpose : packs one 13-bit sample per CLK into 32-bit words (baseline
//           samples 5 x 6 bits per word, signal samples 2 x 13 bits per word)
//           and buffers them in a first-word-fall-through output FIFO.
// Ports   : CLK        clock
//           rst_b      synchronous active-low reset
//           bus        ldtu_sample_packer_if.slave (samples in, words out)
//           fifo_ovf   sticky flag: a word was dropped on a full FIFO
//           ovf_count  dropped-word count, saturating (LDTU_PACK_OVF_CNT_EN)
//           dbg_state  packer state: 0 = BASE, 1 = SIG
//           dbg_cnt    packer slot counter
// Config  : define LDTU_PACK_OVF_CNT_EN to add the ovf_count port/counter.
// ---------------------------------------------------------------------------
module ldtu_sample_packer #(
    parameter int FIFO_DEPTH = 8,
    parameter int PTR_W      = 3
) (
    input  logic                      CLK,
    input  logic                      rst_b,
    ldtu_sample_packer_if.slave       bus,
    output logic                      fifo_ovf,
`ifdef LDTU_PACK_OVF_CNT_EN
    output logic [15:0]               ovf_count,
`endif
    output logic                      dbg_state,
    output logic [2:0]                dbg_cnt
);

    typedef enum logic {
        ST_BASE = 1'b0,
        ST_SIG  = 1'b1
    } state_t;

    state_t      state_q, state_d;
    logic [2:0]  cnt_q, cnt_d;
    logic [5:0]  b_q [4];          // baseline slots 0..3; slot 4 is never stored
    logic [12:0] s0_q;

    logic        b_we;
    logic [1:0]  b_widx;
    logic        s_we;
    logic        emit;
    logic [31:0] emit_word;
    logic [23:0] partial_slots;

    logic [12:0] din;
    logic        is_base;

    assign din     = bus.DATA_to_enc;
    assign is_base = bus.baseline_flag;

    // Partial baseline word: slots at or above cnt are forced to zero, since
    // they may still hold samples from an earlier word.
    always_comb begin
        partial_slots = '0;
        for (int i = 0; i < 4; i++) begin
            if (3'(i) < cnt_q) partial_slots[6*i +: 6] = b_q[i];
        end
    end

    // Packer next-state / emit logic
    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        b_we      = 1'b0;
        b_widx    = cnt_q[1:0];
        s_we      = 1'b0;
        emit      = 1'b0;
        emit_word = '0;
        case (state_q)
            ST_BASE: begin
                if (is_base) begin
                    if (cnt_q == 3'd4) begin
                        emit      = 1'b1;
                        emit_word = {2'b01, din[5:0], b_q[3], b_q[2], b_q[1], b_q[0]};
                        cnt_d     = 3'd0;
                    end else begin
                        b_we  = 1'b1;
                        cnt_d = cnt_q + 3'd1;
                    end
                end else begin
                    if (cnt_q != 3'd0) begin
                        emit      = 1'b1;
                        emit_word = {4'b1110, 1'b0, cnt_q, partial_slots};
                    end
                    state_d = ST_SIG;
                    cnt_d   = 3'd1;
                    s_we    = 1'b1;
                end
            end
            ST_SIG: begin
                if (!is_base) begin
                    if (cnt_q == 3'd1) begin
                        emit      = 1'b1;
                        emit_word = {6'b001010, din, s0_q};
                        cnt_d     = 3'd0;
                    end else begin
                        s_we  = 1'b1;
                        cnt_d = 3'd1;
                    end
                end else begin
                    if (cnt_q == 3'd1) begin
                        emit      = 1'b1;
                        emit_word = {6'b001011, 13'b0, s0_q};
                    end
                    state_d = ST_BASE;
                    cnt_d   = 3'd1;
                    b_we    = 1'b1;
                    b_widx  = 2'd0;
                end
            end
            default: begin
                state_d = ST_BASE;
                cnt_d   = 3'd0;
            end
        endcase
    end

    always_ff @(posedge CLK) begin
        if (!rst_b) begin
            state_q <= ST_BASE;
            cnt_q   <= 3'd0;
            s0_q    <= '0;
            for (int i = 0; i < 4; i++) b_q[i] <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            if (s_we) s0_q <= din;
            if (b_we) b_q[b_widx] <= din[5:0];
        end
    end

    assign dbg_state = state_q;
    assign dbg_cnt   = cnt_q;

    // ---------------- output FIFO ----------------
    logic [31:0]    mem [FIFO_DEPTH];
    logic [PTR_W:0] wr_ptr, rd_ptr;
    logic           empty, full, rd_en, wr_en, drop;

    assign empty = (wr_ptr == rd_ptr);
    assign full  = (wr_ptr[PTR_W] != rd_ptr[PTR_W]) &&
                   (wr_ptr[PTR_W-1:0] == rd_ptr[PTR_W-1:0]);
    assign rd_en = !empty && bus.word_ready;
    // A simultaneous read frees the head entry, so a full FIFO still accepts.
    assign wr_en = emit && (!full || rd_en);
    assign drop  = emit && full && !rd_en;

    assign bus.word_valid = !empty;
    assign bus.word_data  = empty ? 32'd0 : mem[rd_ptr[PTR_W-1:0]];

    always_ff @(posedge CLK) begin
        if (rst_b && wr_en) mem[wr_ptr[PTR_W-1:0]] <= emit_word;
    end

    always_ff @(posedge CLK) begin
        if (!rst_b) begin
            wr_ptr   <= '0;
            rd_ptr   <= '0;
            fifo_ovf <= 1'b0;
        end else begin
            if (wr_en) wr_ptr <= wr_ptr + 1'b1;
            if (rd_en) rd_ptr <= rd_ptr + 1'b1;
            if (drop)  fifo_ovf <= 1'b1;
        end
    end

`ifdef LDTU_PACK_OVF_CNT_EN
    always_ff @(posedge CLK) begin
        if (!rst_b) begin
            ovf_count <= 16'd0;
        end else if (drop && ovf_count != 16'hFFFF) begin
            ovf_count <= ovf_count + 16'd1;
        end
    end
`endif

endmodule

// File: tb/tb_ldtu_sample_packer.sv
// ---------------------------------------------------------------------------
// tb_ldtu_sample_packer
// Self-checking bench for ldtu_sample_packer. A queue-based reference model
// collects pending baseline/signal samples and builds words from the packing
// rules; a second queue models the 8-deep word FIFO.
// ---------------------------------------------------------------------------
module tb_ldtu_sample_packer;

    logic        CLK;
    logic        rst_b;
    logic        fifo_ovf;
    logic        dbg_state;
    logic [2:0]  dbg_cnt;
`ifdef LDTU_PACK_OVF_CNT_EN
    logic [15:0] ovf_count;
`endif

    ldtu_sample_packer_if pif();

    ldtu_sample_packer #(.FIFO_DEPTH(8), .PTR_W(3)) dut (
        .CLK       (CLK),
        .rst_b     (rst_b),
        .bus       (pif.slave),
        .fifo_ovf  (fifo_ovf),
`ifdef LDTU_PACK_OVF_CNT_EN
        .ovf_count (ovf_count),
`endif
        .dbg_state (dbg_state),
        .dbg_cnt   (dbg_cnt)
    );

    // ---------------- clock ----------------
    initial CLK = 1'b0;
    always #5 CLK = ~CLK;

    // ---------------- scoreboard / model ----------------
    logic [31:0] exp_q[$];
    logic [5:0]  bq[$];
    logic [12:0] sq[$];
    logic        m_ovf;
    int          m_ovf_cnt;
    int          n_cmp;
    int          n_err;

    task automatic model_step(input logic bl, input logic [12:0] d, input logic rdy);
        logic        has_word;
        logic [31:0] w;
        if (!rst_b) begin
            exp_q.delete(); bq.delete(); sq.delete();
            m_ovf = 1'b0; m_ovf_cnt = 0;
            return;
        end
        has_word = 1'b0;
        w = '0;
        if (bl) begin
            if (sq.size() == 1) begin
                has_word = 1'b1;
                w = {6'b001011, 13'b0, sq[0]};
                sq.delete();
            end
            bq.push_back(d[5:0]);
            if (bq.size() == 5) begin
                has_word = 1'b1;
                w = {2'b01, bq[4], bq[3], bq[2], bq[1], bq[0]};
                bq.delete();
            end
        end else begin
            if (bq.size() > 0) begin
                has_word = 1'b1;
                w = {4'hE, 4'(bq.size()), 24'b0};
                for (int i = 0; i < bq.size(); i++) w[6*i +: 6] = bq[i];
                bq.delete();
            end
            sq.push_back(d);
            if (sq.size() == 2) begin
                has_word = 1'b1;
                w = {6'b001010, sq[1], sq[0]};
                sq.delete();
            end
        end
        if (rdy && exp_q.size() > 0) void'(exp_q.pop_front());
        if (has_word) begin
            if (exp_q.size() < 8) begin
                exp_q.push_back(w);
            end else begin
                m_ovf = 1'b1;
                if (m_ovf_cnt < 65535) m_ovf_cnt++;
            end
        end
    endtask

    // ---------------- driver tasks ----------------
    task automatic cycle(input logic bl, input logic [12:0] d, input logic rdy);
        pif.baseline_flag = bl;
        pif.DATA_to_enc   = d;
        pif.word_ready    = rdy;
        @(posedge CLK);
        model_step(bl, d, rdy);
        #1;
    endtask

    task automatic do_reset();
        rst_b = 1'b0;
        cycle(1'b0, 13'd0, 1'b0);
        rst_b = 1'b1;
    endtask

    // ---------------- tests ----------------
    task automatic test_reset();
        do_reset();
        n_cmp++; if (pif.word_valid !== 1'b0) begin n_err++; $display("FAIL reset_valid: got %b expected 0", pif.word_valid); end
        n_cmp++; if (pif.word_data !== 32'd0) begin n_err++; $display("FAIL reset_data: got %h expected 00000000", pif.word_data); end
        n_cmp++; if (fifo_ovf !== 1'b0) begin n_err++; $display("FAIL reset_ovf: got %b expected 0", fifo_ovf); end
        n_cmp++; if (dbg_cnt !== 3'd0) begin n_err++; $display("FAIL reset_cnt: got %0d expected 0", dbg_cnt); end
`ifdef LDTU_PACK_OVF_CNT_EN
        n_cmp++; if (ovf_count !== 16'd0) begin n_err++; $display("FAIL reset_ovf_count: got %0d expected 0", ovf_count); end
`endif
    endtask

    task automatic test_baseline_word();
        do_reset();
        for (int i = 1; i <= 4; i++) begin
            cycle(1'b1, 13'(i), 1'b1);
            n_cmp++; if (pif.word_valid !== 1'b0) begin n_err++; $display("FAIL t1_early_valid: sample %0d got %b expected 0", i, pif.word_valid); end
        end
        cycle(1'b1, 13'd5, 1'b1);
        n_cmp++; if (pif.word_valid !== 1'b1) begin n_err++; $display("FAIL t1_valid: got %b expected 1", pif.word_valid); end
        n_cmp++; if (pif.word_data !== 32'h45103081) begin n_err++; $display("FAIL t1_word: got %h expected 45103081", pif.word_data); end
        cycle(1'b1, 13'd0, 1'b1);
        n_cmp++; if (pif.word_valid !== 1'b0) begin n_err++; $display("FAIL t1_one_cycle: got %b expected 0", pif.word_valid); end
    endtask

    task automatic test_signal_pair();
        do_reset();
        cycle(1'b0, 13'h0123, 1'b1);
        n_cmp++; if (pif.word_valid !== 1'b0) begin n_err++; $display("FAIL t2_early_valid: got %b expected 0", pif.word_valid); end
        cycle(1'b0, 13'h1ABC, 1'b1);
        n_cmp++; if (pif.word_valid !== 1'b1) begin n_err++; $display("FAIL t2_valid: got %b expected 1", pif.word_valid); end
        n_cmp++; if (pif.word_data !== 32'h2B578123) begin n_err++; $display("FAIL t2_word: got %h expected 2B578123", pif.word_data); end
    endtask

    task automatic test_partial_baseline();
        do_reset();
        cycle(1'b1, 13'd7, 1'b1);
        cycle(1'b1, 13'd8, 1'b1);
        cycle(1'b1, 13'd9, 1'b1);
        cycle(1'b0, 13'h0555, 1'b1);
        n_cmp++; if (pif.word_data !== 32'hE3009207 || pif.word_valid !== 1'b1) begin n_err++; $display("FAIL t3_partial: got %h/%b expected E3009207/1", pif.word_data, pif.word_valid); end
        cycle(1'b0, 13'h0AAA, 1'b1);
        n_cmp++; if (pif.word_data !== {6'b001010, 13'h0AAA, 13'h0555}) begin n_err++; $display("FAIL t3_carry_s0: got %h expected %h", pif.word_data, {6'b001010, 13'h0AAA, 13'h0555}); end
    endtask

    task automatic test_signal_tail();
        do_reset();
        cycle(1'b0, 13'h0FFF, 1'b1);
        cycle(1'b1, 13'h0003, 1'b1);
        n_cmp++; if (pif.word_data !== 32'h2C000FFF || pif.word_valid !== 1'b1) begin n_err++; $display("FAIL t4_tail: got %h/%b expected 2C000FFF/1", pif.word_data, pif.word_valid); end
        n_cmp++; if (dbg_state !== 1'b0 || dbg_cnt !== 3'd1) begin n_err++; $display("FAIL t4_restart: got state %b cnt %0d expected 0/1", dbg_state, dbg_cnt); end
    endtask

    task automatic test_overflow();
        logic [12:0] d[18];
        logic [31:0] w;
        do_reset();
        for (int i = 0; i < 18; i++) begin
            d[i] = 13'($urandom);
            cycle(1'b0, d[i], 1'b0);
        end
        n_cmp++; if (fifo_ovf !== 1'b1) begin n_err++; $display("FAIL t5_ovf: got %b expected 1", fifo_ovf); end
        n_cmp++; if (pif.word_valid !== 1'b1) begin n_err++; $display("FAIL t5_valid: got %b expected 1", pif.word_valid); end
`ifdef LDTU_PACK_OVF_CNT_EN
        n_cmp++; if (ovf_count !== 16'd1) begin n_err++; $display("FAIL t5_ovf_count: got %0d expected 1", ovf_count); end
`endif
        for (int k = 0; k < 8; k++) begin
            w = {6'b001010, d[2*k+1], d[2*k]};
            n_cmp++; if (pif.word_data !== w || pif.word_valid !== 1'b1) begin n_err++; $display("FAIL t5_drain: word %0d got %h/%b expected %h/1", k, pif.word_data, pif.word_valid, w); end
            cycle(1'b1, 13'($urandom), 1'b1);
        end
        n_cmp++; if (fifo_ovf !== 1'b1) begin n_err++; $display("FAIL t5_ovf_sticky: got %b expected 1", fifo_ovf); end
    endtask

    task automatic test_reset_mid();
        do_reset();
        for (int i = 0; i < 6; i++) cycle(1'b0, 13'($urandom), 1'b0);
        cycle(1'b1, 13'd1, 1'b0);
        cycle(1'b1, 13'd2, 1'b0);
        n_cmp++; if (pif.word_valid !== 1'b1) begin n_err++; $display("FAIL t6_buffered: got %b expected 1", pif.word_valid); end
        do_reset();
        n_cmp++; if (pif.word_valid !== 1'b0 || pif.word_data !== 32'd0) begin n_err++; $display("FAIL t6_cleared: got %b/%h expected 0/00000000", pif.word_valid, pif.word_data); end
        for (int i = 0; i < 3; i++) begin
            cycle(1'b1, 13'd3, 1'b1);
            n_cmp++; if (pif.word_valid !== 1'b0) begin n_err++; $display("FAIL t6_stale: cycle %0d got %b expected 0", i, pif.word_valid); end
        end
    endtask

    task automatic test_random();
        logic bl, rdy;
        do_reset();
        for (int i = 0; i < 600; i++) begin
            bl  = ($urandom_range(0, 2) != 0);
            rdy = (i % 200 < 120) ? ($urandom_range(0, 3) != 0) : ($urandom_range(0, 5) == 0);
            cycle(bl, 13'($urandom), rdy);
            n_cmp++; if (pif.word_valid !== (exp_q.size() > 0)) begin n_err++; $display("FAIL rnd_valid: cycle %0d got %b expected %b", i, pif.word_valid, exp_q.size() > 0); end
            if (exp_q.size() > 0) begin
                n_cmp++; if (pif.word_data !== exp_q[0]) begin n_err++; $display("FAIL rnd_data: cycle %0d got %h expected %h", i, pif.word_data, exp_q[0]); end
            end
            n_cmp++; if (fifo_ovf !== m_ovf) begin n_err++; $display("FAIL rnd_ovf: cycle %0d got %b expected %b", i, fifo_ovf, m_ovf); end
`ifdef LDTU_PACK_OVF_CNT_EN
            n_cmp++; if (ovf_count !== 16'(m_ovf_cnt)) begin n_err++; $display("FAIL rnd_ovf_count: cycle %0d got %0d expected %0d", i, ovf_count, m_ovf_cnt); end
`endif
        end
    endtask

    // ---------------- sequence + report ----------------
    initial begin
        n_cmp = 0;
        n_err = 0;
        m_ovf = 1'b0;
        m_ovf_cnt = 0;
        rst_b = 1'b0;
        pif.baseline_flag = 1'b0;
        pif.DATA_to_enc   = '0;
        pif.word_ready    = 1'b0;
        repeat (2) @(posedge CLK);
        #1;
        test_reset();
        test_baseline_word();
        test_signal_pair();
        test_partial_baseline();
        test_signal_tail();
        test_overflow();
        test_reset_mid();
        test_random();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
